// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game controller for a two-paddle pong game.
//
// The ball advances once per frame_tick. It bounces off the top and bottom
// walls and off either paddle. A ball that passes a paddle scores a point
// for the opposite player. The first player to reach WIN_SCORE ends the game.
//
// Ports
//   vga_clk     pixel clock; all state changes on its rising edge
//   rst_n       synchronous, active-low reset
//   frame_tick  one-cycle pulse at the start of vertical blanking
//   pb_serve    serve/restart button, active-high, already synchronized
//   p1_y, p2_y  top row of the left and right paddle
//   ball_x/y    ball left column / top row
//   score1/2    left / right player score
//   state       IDLE=00, SERVE=01, PLAY=10, OVER=11
//   game_over   high while state is OVER
//   hit_pulse   one-cycle pulse after a paddle hit
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PAD_W        = 10,
  parameter int PAD_H        = 80,
  parameter int P1_X         = 50,
  parameter int P2_X         = 590,
  parameter int SPEED        = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pb_serve,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] state,
  output logic       game_over,
  output logic       hit_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_e;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0]       CENTRE_X = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]       CENTRE_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]       Y_LIMIT  = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]       L_STOP   = 10'(P1_X + PAD_W);
  localparam logic [9:0]       R_STOP   = 10'(P2_X - BALL_SIZE);
  localparam logic signed [10:0] SPD    = 11'(SPEED);
  localparam logic signed [10:0] BSZ    = 11'(BALL_SIZE);
  localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] L_FACE = 11'(P1_X + PAD_W);
  localparam logic signed [10:0] L_BACK = 11'(P1_X);
  localparam logic signed [10:0] R_FACE = 11'(P2_X);
  localparam logic signed [10:0] R_BACK = 11'(P2_X + PAD_W);
  localparam logic [10:0]      BSZ_U    = 11'(BALL_SIZE);
  localparam logic [10:0]      PADH_U   = 11'(PAD_H);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic [3:0]       score1_q, score1_d;
  logic [3:0]       score2_q, score2_d;
  logic             dx_q, dx_d;
  logic             dy_q, dy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pb_q, pb_d;
  logic             hit_q, hit_d;
  logic             over_q, over_d;

  // Next position is computed one bit wider and signed so that a step past
  // column/row 0 shows up as a negative value instead of wrapping to ~1023.
  logic signed [10:0] cur_x, cur_y, next_x, next_y;
  logic [10:0]        ball_top, ball_bot;
  logic               p1_ovl, p2_ovl;
  logic               hit_l, hit_r, miss_l, miss_r;
  logic               serve_evt;
  logic [3:0]         s1_inc, s2_inc;

  assign cur_x  = $signed({1'b0, ball_x_q});
  assign cur_y  = $signed({1'b0, ball_y_q});
  assign next_x = dx_q ? cur_x + SPD : cur_x - SPD;
  assign next_y = dy_q ? cur_y + SPD : cur_y - SPD;

  // Vertical overlap uses the ball row before this frame's move.
  assign ball_top = {1'b0, ball_y_q};
  assign ball_bot = ball_top + BSZ_U;
  assign p1_ovl   = (ball_bot > {1'b0, p1_y}) && (ball_top < ({1'b0, p1_y} + PADH_U));
  assign p2_ovl   = (ball_bot > {1'b0, p2_y}) && (ball_top < ({1'b0, p2_y} + PADH_U));

  assign hit_l  = !dx_q && (next_x <= L_FACE) && ((next_x + BSZ) > L_BACK) && p1_ovl;
  assign hit_r  = dx_q && ((next_x + BSZ) >= R_FACE) && (next_x < R_BACK) && p2_ovl;
  assign miss_l = (next_x <= 11'sd0);
  assign miss_r = (next_x >= X_MAX);

  assign serve_evt = pb_serve && !pb_q;

  // Scores stop at WIN_SCORE instead of wrapping.
  assign s1_inc = (score1_q == WIN) ? score1_q : score1_q + 4'd1;
  assign s2_inc = (score2_q == WIN) ? score2_q : score2_q + 4'd1;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    score1_d = score1_q;
    score2_d = score2_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    pb_d     = pb_serve;
    hit_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
        if (serve_evt) begin
          state_d = SERVE;
          cnt_d   = '0;
        end
      end

      SERVE: begin
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = PLAY;
        end
      end

      PLAY: begin
        if (frame_tick) begin
          // Vertical walls, independent of what happens horizontally.
          if (next_y <= 11'sd0) begin
            ball_y_d = '0;
            dy_d     = 1'b1;
          end else if (next_y >= Y_MAX) begin
            ball_y_d = Y_LIMIT;
            dy_d     = 1'b0;
          end else begin
            ball_y_d = next_y[9:0];
          end

          // Paddle hits are checked before misses.
          if (hit_l) begin
            ball_x_d = L_STOP;
            dx_d     = 1'b1;
            hit_d    = 1'b1;
          end else if (hit_r) begin
            ball_x_d = R_STOP;
            dx_d     = 1'b0;
            hit_d    = 1'b1;
          end else if (miss_l || miss_r) begin
            // A point recentres the ball and overrides any wall bounce;
            // dy keeps its pre-tick value.
            ball_x_d = CENTRE_X;
            ball_y_d = CENTRE_Y;
            dx_d     = !dx_q;
            dy_d     = dy_q;
            if (miss_l) score2_d = s2_inc;
            else        score1_d = s1_inc;
            if ((miss_l && s2_inc == WIN) || (miss_r && s1_inc == WIN)) begin
              state_d = OVER;
            end else begin
              state_d = SERVE;
              cnt_d   = '0;
            end
          end else begin
            ball_x_d = next_x[9:0];
          end
        end
      end

      OVER: begin
        if (serve_evt) begin
          score1_d = '0;
          score2_d = '0;
          ball_x_d = CENTRE_X;
          ball_y_d = CENTRE_Y;
          dx_d     = 1'b1;
          dy_d     = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    over_d = (state_d == OVER);
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of ordering.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ball_x_q <= CENTRE_X;
      ball_y_q <= CENTRE_Y;
      score1_q <= '0;
      score2_q <= '0;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      cnt_q    <= '0;
      pb_q     <= 1'b0;
      hit_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      pb_q     <= pb_d;
      hit_q    <= hit_d;
      over_q   <= over_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign state     = state_q;
  assign game_over = over_q;
  assign hit_pulse = hit_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed bench for pong_game_ctrl.
//
// The stimulus side drives inputs and, for every cycle it wants checked,
// pushes the hand-computed expected outputs into a queue. A separate monitor
// pops one entry per checked cycle and compares it on the falling edge after
// the DUT has updated. Ball trajectories below come from working out
// x = x0 +/- 2k and y = y0 +/- 2k by hand between wall and paddle events.
module tb_pong_game_ctrl;

  localparam int CX      = 316;
  localparam int CY      = 236;
  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_OVER  = 3;
  localparam logic [9:0] PARK = 10'd1000;  // paddle row no ball can overlap

  logic       vga_clk;
  logic       rst_n;
  logic       frame_tick;
  logic       pb_serve;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] state;
  logic       game_over;
  logic       hit_pulse;

  pong_game_ctrl dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .pb_serve   (pb_serve),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score1     (score1),
    .score2     (score2),
    .state      (state),
    .game_over  (game_over),
    .hit_pulse  (hit_pulse)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct {
    string name;
    bit    chk_xy;
    int    x;
    int    y;
    int    s1;
    int    s2;
    int    st;
    bit    go;
    bit    hit;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t nul;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_strobe = 1'b0;
  bit   strobe_d   = 1'b0;
  bit   pb_lvl     = 1'b0;

  function automatic exp_t mk(input string n, input bit cxy, input int x, input int y,
                              input int s1, input int s2, input int st,
                              input bit go, input bit hit);
    exp_t e;
    e.name = n; e.chk_xy = cxy; e.x = x; e.y = y;
    e.s1 = s1; e.s2 = s2; e.st = st; e.go = go; e.hit = hit;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge vga_clk) strobe_d <= chk_strobe;

  always @(negedge vga_clk) begin
    if (strobe_d) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_xy) begin
          check({mon_e.name, ".ball_x"}, 32'(ball_x), 32'(mon_e.x));
          check({mon_e.name, ".ball_y"}, 32'(ball_y), 32'(mon_e.y));
        end
        check({mon_e.name, ".score1"},    32'(score1),    32'(mon_e.s1));
        check({mon_e.name, ".score2"},    32'(score2),    32'(mon_e.s2));
        check({mon_e.name, ".state"},     32'(state),     32'(mon_e.st));
        check({mon_e.name, ".game_over"}, 32'(game_over), 32'(mon_e.go));
        check({mon_e.name, ".hit_pulse"}, 32'(hit_pulse), 32'(mon_e.hit));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit tk, input bit rs, input bit chk, input exp_t e);
    frame_tick = tk;
    pb_serve   = pb_lvl;
    rst_n      = !rs;
    if (chk) exp_q.push_back(e);
    chk_strobe = chk;
    @(posedge vga_clk);
    #1;
    frame_tick = 1'b0;
    rst_n      = 1'b1;
    chk_strobe = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, nul);
      drive(1'b0, 1'b0, 1'b0, nul);
    end
  endtask

  // Checked tick: the tick cycle itself, then the idle cycle after it with
  // identical outputs except that hit_pulse must already be low again.
  task automatic tick_chk(input exp_t e);
    exp_t e2;
    e2 = e;
    e2.name = {e.name, "_after"};
    e2.hit = 1'b0;
    drive(1'b1, 1'b0, 1'b1, e);
    drive(1'b0, 1'b0, 1'b1, e2);
  endtask

  task automatic press(input exp_t e);
    pb_lvl = 1'b1;
    drive(1'b0, 1'b0, 1'b1, e);
    pb_lvl = 1'b0;
    drive(1'b0, 1'b0, 1'b0, nul);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    nul = mk("none", 1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b0; frame_tick = 1'b0; pb_serve = 1'b0;
    p1_y = PARK; p2_y = PARK;

    // Reset, with a tick present that must be ignored.
    drive(1'b1, 1'b1, 1'b1, mk("reset", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    drive(1'b0, 1'b0, 1'b1, mk("idle", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    tick_chk(mk("idle_tick_ignored", 1, CX, CY, 0, 0, S_IDLE, 0, 0));

    // Serve: PLAY exactly on the 60th tick.
    press(mk("serve_press", 1, CX, CY, 0, 0, S_SERVE, 0, 0));
    tick_n(58);
    tick_chk(mk("serve_59", 1, CX, CY, 0, 0, S_SERVE, 0, 0));
    tick_chk(mk("serve_60", 1, CX, CY, 0, 0, S_PLAY, 0, 0));

    // dx=1, dy=1 from centre; bottom wall at k=118, right miss at k=158.
    tick_chk(mk("play_k1", 1, 318, 238, 0, 0, S_PLAY, 0, 0));
    tick_n(116);
    tick_chk(mk("bottom_wall", 1, 552, 472, 0, 0, S_PLAY, 0, 0));
    tick_chk(mk("bottom_wall_next", 1, 554, 470, 0, 0, S_PLAY, 0, 0));
    tick_n(37);
    tick_chk(mk("before_right_miss", 1, 630, 394, 0, 0, S_PLAY, 0, 0));
    tick_chk(mk("right_miss", 1, CX, CY, 1, 0, S_SERVE, 0, 0));

    // Now dx=0, dy=0. Top wall at j=118, left paddle hit at j=128.
    p1_y = 10'd0;
    tick_n(59);
    tick_chk(mk("serve2_60", 1, CX, CY, 1, 0, S_PLAY, 0, 0));
    tick_n(116);
    tick_chk(mk("near_top_dy0", 1, 82, 2, 1, 0, S_PLAY, 0, 0));
    tick_chk(mk("top_wall", 1, 80, 0, 1, 0, S_PLAY, 0, 0));
    tick_chk(mk("top_wall_next", 1, 78, 2, 1, 0, S_PLAY, 0, 0));
    tick_n(7);
    tick_chk(mk("before_left_hit", 1, 62, 18, 1, 0, S_PLAY, 0, 0));
    tick_chk(mk("left_hit", 1, 60, 20, 1, 0, S_PLAY, 0, 1));

    // dx=1, dy=1 from (60,20): bottom wall m=226, right paddle hit m=261.
    p2_y = 10'd400;
    tick_n(225);
    tick_chk(mk("bottom_wall2", 1, 512, 472, 1, 0, S_PLAY, 0, 0));
    tick_n(33);
    tick_chk(mk("before_right_hit", 1, 580, 404, 1, 0, S_PLAY, 0, 0));
    tick_chk(mk("right_hit", 1, 582, 402, 1, 0, S_PLAY, 0, 1));

    // dx=0 from (582,402): top wall n=201, passes below left paddle, miss n=291.
    tick_n(200);
    tick_chk(mk("top_wall2", 1, 180, 0, 1, 0, S_PLAY, 0, 0));
    tick_n(88);
    tick_chk(mk("before_left_miss", 1, 2, 178, 1, 0, S_PLAY, 0, 0));
    tick_chk(mk("left_miss", 1, CX, CY, 1, 1, S_SERVE, 0, 0));

    // Alternating right/left misses from (1,1) up to (8,8), then 9:8 -> OVER.
    p1_y = PARK; p2_y = PARK;
    for (int r = 1; r <= 15; r++) begin
      tick_n(60 + 157);
      tick_chk(mk($sformatf("round%0d_miss", r), 1, CX, CY, 1 + (r + 1) / 2, 1 + r / 2,
                  (r == 15) ? S_OVER : S_SERVE, (r == 15), 0));
    end
    tick_chk(mk("over_tick_ignored", 1, CX, CY, 9, 8, S_OVER, 1, 0));

    // Restart with the button held: no second serve until released.
    pb_lvl = 1'b1;
    drive(1'b0, 1'b0, 1'b1, mk("over_restart", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    tick_chk(mk("pb_held_tick", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    drive(1'b0, 1'b0, 1'b1, mk("pb_held_idle", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    pb_lvl = 1'b0;
    drive(1'b0, 1'b0, 1'b1, mk("pb_released", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    pb_lvl = 1'b1;
    drive(1'b1, 1'b0, 1'b1, mk("serve_with_tick", 1, CX, CY, 0, 0, S_SERVE, 0, 0));
    pb_lvl = 1'b0;
    tick_n(58);
    tick_chk(mk("serve3_59", 1, CX, CY, 0, 0, S_SERVE, 0, 0));
    tick_chk(mk("serve3_60", 1, CX, CY, 0, 0, S_PLAY, 0, 0));
    pb_lvl = 1'b1;
    tick_chk(mk("play_pb_ignored", 1, 318, 238, 0, 0, S_PLAY, 0, 0));
    pb_lvl = 1'b0;
    tick_chk(mk("play3_k2", 1, 320, 240, 0, 0, S_PLAY, 0, 0));

    // Reset mid-PLAY, with a tick in the same cycle.
    drive(1'b1, 1'b1, 1'b1, mk("reset_mid_play", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    tick_chk(mk("idle_after_reset", 1, CX, CY, 0, 0, S_IDLE, 0, 0));

    // Reset mid-SERVE must clear the serve counter.
    press(mk("serve4_press", 1, CX, CY, 0, 0, S_SERVE, 0, 0));
    tick_n(30);
    drive(1'b0, 1'b1, 1'b1, mk("reset_mid_serve", 1, CX, CY, 0, 0, S_IDLE, 0, 0));
    press(mk("serve5_press", 1, CX, CY, 0, 0, S_SERVE, 0, 0));
    tick_n(58);
    tick_chk(mk("serve5_59", 1, CX, CY, 0, 0, S_SERVE, 0, 0));
    tick_chk(mk("serve5_60", 1, CX, CY, 0, 0, S_PLAY, 0, 0));
    tick_chk(mk("play5_k1", 1, 318, 238, 0, 0, S_PLAY, 0, 0));
    tick_n(156);
    tick_chk(mk("play5_miss", 1, CX, CY, 1, 0, S_SERVE, 0, 0));
    tick_n(10);
    drive(1'b1, 1'b1, 1'b1, mk("reset_with_score", 1, CX, CY, 0, 0, S_IDLE, 0, 0));

    drive(1'b0, 1'b0, 1'b0, nul);
    drive(1'b0, 1'b0, 1'b0, nul);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters, one per line, SHALL be:
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- BALL_SIZE, 8, ball edge length in pixels.
- PAD_W, 10, paddle width.
- PAD_H, 80, paddle height.
- P1_X, 50, left paddle left edge.
- P2_X, 590, right paddle left edge.
- SPEED, 2, pixels moved per frame per axis.
- WIN_SCORE, 9, points needed to win.
- SERVE_FRAMES, 60, frames held in SERVE.

REQ-002 Ports, one per line, SHALL be:
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- pb_serve  in  1  serve/restart button, active-high, already synchronized.
- p1_y  in  10  left paddle top row.
- p2_y  in  10  right paddle top row.
- ball_x  out  10  ball left column.
- ball_y  out  10  ball top row.
- score1  out  4  left player score.
- score2  out  4  right player score.
- state  out  2  IDLE=00, SERVE=01, PLAY=10, OVER=11.
- game_over  out  1  high while state==OVER.
- hit_pulse  out  1  one-cycle pulse on any paddle hit.

Function
REQ-003 All outputs SHALL be registered and change only on a vga_clk rising edge.
REQ-004 pb_serve SHALL be rising-edge detected internally; a serve event is pb_serve=1 with its registered previous value=0.
REQ-005 IDLE: ball held at centre (316,236); a serve event -> SERVE, serve counter cleared.
REQ-006 SERVE: ball held at centre; counter increments per frame_tick; on the tick that brings it to SERVE_FRAMES -> PLAY.
REQ-007 PLAY: on each frame_tick, next_x=ball_x±SPEED and next_y=ball_y±SPEED per direction bits dx/dy (1=+); results SHALL appear on ball_x/ball_y on the cycle after the tick.
REQ-008 Next-position arithmetic SHALL use 11-bit signed values; no 10-bit wrap-around SHALL reach the outputs.
REQ-009 Vertical wall: next_y<=0 -> ball_y=0, dy=1; next_y>=SCREEN_H-BALL_SIZE -> ball_y=SCREEN_H-BALL_SIZE, dy=0.
REQ-010 Left paddle hit (dx=0, next_x<=P1_X+PAD_W, next_x+BALL_SIZE>P1_X, ball_y+BALL_SIZE>p1_y, ball_y<p1_y+PAD_H) -> ball_x=P1_X+PAD_W, dx=1, hit_pulse=1 for one cycle.
REQ-011 Right paddle hit (dx=1, next_x+BALL_SIZE>=P2_X, next_x<P2_X+PAD_W, same vertical overlap against p2_y) -> ball_x=P2_X-BALL_SIZE, dx=0, hit_pulse=1.
REQ-012 Miss: with no paddle hit, next_x<=0 -> score2+1; next_x>=SCREEN_W-BALL_SIZE -> score1+1; ball recentred, dx inverted, dy unchanged.
REQ-013 Paddle hit SHALL take priority over miss; the vertical-wall and horizontal rules SHALL apply independently in the same tick.
REQ-014 After a point, a score equal to WIN_SCORE -> OVER; otherwise -> SERVE with counter cleared.
REQ-015 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-016 OVER: ball and scores held; serve event -> scores cleared, ball centred, dx=1, dy=1, -> IDLE.
REQ-017 frame_tick SHALL be ignored in IDLE and OVER; serve events SHALL be ignored in SERVE and PLAY.
REQ-018 A frame_tick and a serve event in the same cycle SHALL be handled per the current state only; at most one transition per cycle.
REQ-019 hit_pulse SHALL be 0 in every cycle except the one following a hit tick.

Reset
REQ-020 With rst_n=0 at a clock edge, in any state, the next outputs SHALL be: ball_x=316, ball_y=236, score1=0, score2=0, state=IDLE, game_over=0, hit_pulse=0; internally dx=1, dy=1, serve counter=0, pb edge register=0.
REQ-021 Reset asserted mid-PLAY or mid-SERVE SHALL discard all progress; no partial update SHALL survive.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, pulse pb_serve, issue 60 ticks -> state 00->01->10 exactly on the 60th tick.
- PLAY, ball (316,2), dy=0, one tick -> ball_y=0, dy=1; next tick -> ball_y=2.
- ball (62,100), dx=0, p1_y=80, one tick -> ball_x=60, dx=1, hit_pulse high for one cycle.
- ball (2,300), dx=0, p1_y=0, one tick -> score2=1, ball (316,236), state=SERVE.
- score1=8, right miss -> score1=9, state=OVER, game_over=1; pb_serve edge -> scores 0, state=IDLE.
- Hold pb_serve high through OVER->IDLE -> no second serve until released and pressed again; reset mid-PLAY -> all reset values next cycle.
